// File: rtl/instr_issuer.sv
`default_nettype none
// ============================================================================
// Module      : instr_issuer
// Description : Loads a short program of 16-bit instructions and issues them
//               one at a time over a valid/ready handshake, waiting for each
//               32-bit result. Optional macro: ISSUE_OPCODE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_issuer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = 3,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned NUM_OPS = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic [15:0]   ld_data,
    input  logic          clr,
    input  logic          start,
    output logic [15:0]   ins,
    output logic          ins_valid,
    input  logic          ins_ready,
    input  logic          res_valid,
    input  logic [31:0]   res_data,
    output logic [31:0]   last_res,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] c_depth    = (AW+1)'(DEPTH);
    localparam logic [7:0]  c_tmo_last = 8'(TIMEOUT - 1);

    state_t         r_state;
    state_t         w_next;
    logic [15:0]    r_buf [DEPTH];
    logic [AW-1:0]  r_ptr;
    logic [AW-1:0]  w_ptr_inc;
    logic [AW:0]    r_count;
    logic [7:0]     r_timer;
    logic [15:0]    r_ins;
    logic           r_ins_valid;
    logic [31:0]    r_last_res;
    logic           r_err;
    logic           w_full;
    logic           w_last;
    logic           w_hs;
    logic           w_timeout;
    logic           w_op_ok;
    logic           w_load;
    logic           w_load_ok;

`ifdef ISSUE_OPCODE_CHECK_EN
    assign w_op_ok = ({28'd0, ld_data[15:12]} < NUM_OPS);
`else
    // Filtering disabled: every opcode is loadable.
    assign w_op_ok = (NUM_OPS >= 0);
`endif

    assign w_full    = (r_count == c_depth);
    assign w_last    = ({1'b0, r_ptr} == (r_count - 1'b1));
    assign w_ptr_inc = r_ptr + 1'b1;
    assign w_hs      = r_ins_valid && ins_ready;
    assign w_timeout = (r_timer == c_tmo_last);
    assign w_load    = (r_state == S_IDLE) && ld_en && !clr && !start;
    assign w_load_ok = w_load && !w_full && w_op_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!clr && start) begin
                    w_next = (r_count == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_hs) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (res_valid) begin
                    w_next = w_last ? S_DONE : S_ISSUE;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= '0;
            r_ptr       <= '0;
            r_ins       <= '0;
            r_ins_valid <= 1'b0;
            r_last_res  <= '0;
            r_err       <= 1'b0;
            r_timer     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr) begin
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end else if (start) begin
                        r_ptr <= '0;
                        if (r_count != '0) begin
                            r_ins       <= r_buf[0];
                            r_ins_valid <= 1'b1;
                        end
                    end else if (ld_en) begin
                        if (w_full || !w_op_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_hs) begin
                        r_ins_valid <= 1'b0;
                        r_timer     <= '0;
                    end
                end
                S_WAIT: begin
                    if (res_valid) begin
                        r_last_res <= res_data;
                        if (w_last) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr       <= w_ptr_inc;
                            r_ins       <= r_buf[w_ptr_inc];
                            r_ins_valid <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        // Abort: result never came back, flag and return home.
                        r_err <= 1'b1;
                        r_ptr <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DONE: begin
                    r_ptr <= '0;
                end
                default: begin
                    r_ptr <= '0;
                end
            endcase
        end
    end

    // Program storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_buf[r_count[AW-1:0]] <= ld_data;
        end
    end

    assign ins       = r_ins;
    assign ins_valid = r_ins_valid;
    assign last_res  = r_last_res;
    assign err       = r_err;
    assign count     = r_count;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_instr_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_issuer
// Description : Randomised scoreboard bench for instr_issuer with a program
//               model, a data-path responder and a decoupled output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_issuer;

    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int TIMEOUT = 255;
    localparam int NUM_OPS = 10;
`ifdef ISSUE_OPCODE_CHECK_EN
    localparam bit C_CHK = 1'b1;
`else
    localparam bit C_CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_en, clr, start;
    logic [15:0]   ld_data;
    logic [15:0]   ins;
    logic          ins_valid, ins_ready;
    logic          res_valid;
    logic [31:0]   res_data;
    logic [31:0]   last_res;
    logic          busy, done, err;
    logic [AW:0]   count;

    instr_issuer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT), .NUM_OPS(NUM_OPS)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_data(ld_data), .clr(clr),
        .start(start), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .res_valid(res_valid), .res_data(res_data), .last_res(last_res),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    int            m_count  = 0;
    bit            m_err    = 1'b0;
    logic [15:0]   m_buf [DEPTH];
    logic [15:0]   exp_ins [$];
    logic [31:0]   exp_last = '0;
    int            done_cnt = 0;
    int            hs_total = 0;
    logic          hs_pulse = 1'b0;
    int            rdy_mode = 1;
    bit            resp_en  = 1'b1;
    int            resp_delay = -1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Data-path model: drives ins_ready and answers each handshake.
    initial begin : responder
        int resp_cnt;
        resp_cnt  = -1;
        ins_ready = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        forever begin
            tick();
            res_valid = 1'b0;
            case (rdy_mode)
                0:       ins_ready = 1'b0;
                1:       ins_ready = 1'b1;
                default: ins_ready = 1'($urandom_range(0, 1));
            endcase
            if (!rst) begin
                resp_cnt = -1;
                exp_last = '0;
            end else if (!resp_en) begin
                resp_cnt = -1;
            end else begin
                if (hs_pulse) resp_cnt = (resp_delay < 0) ? int'($urandom_range(0, 3)) : resp_delay;
                if (resp_cnt == 0) begin
                    res_valid = 1'b1;
                    res_data  = $urandom;
                    exp_last  = res_data;
                    resp_cnt  = -1;
                end else if (resp_cnt > 0) begin
                    resp_cnt--;
                end
            end
        end
    end

    initial begin : monitor
        bit          prev_stall;
        logic [15:0] prev_ins;
        logic [15:0] e;
        prev_stall = 1'b0;
        prev_ins   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
                hs_pulse   = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("ins_valid_held", 32'(ins_valid), 32'd1);
                    check("ins_stable", 32'(ins), 32'(prev_ins));
                end
                prev_stall = ins_valid && !ins_ready;
                prev_ins   = ins;
                hs_pulse   = ins_valid && ins_ready;
                if (hs_pulse) begin
                    hs_total++;
                    check("ins_expected_avail", 32'(exp_ins.size() != 0), 32'd1);
                    if (exp_ins.size() != 0) begin
                        e = exp_ins.pop_front();
                        check("ins_order", 32'(ins), 32'(e));
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("done_last_res", last_res, exp_last);
                    check("done_all_issued", 32'(exp_ins.size()), 32'd0);
                end
            end
        end
    end

    task automatic load(input logic [15:0] w);
        ld_data = w;
        ld_en   = 1'b1;
        tick();
        ld_en   = 1'b0;
        if (C_CHK && (int'(w[15:12]) >= NUM_OPS)) m_err = 1'b1;
        else if (m_count == DEPTH)                m_err = 1'b1;
        else begin
            m_buf[m_count] = w;
            m_count++;
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_count = 0;
        m_err   = 1'b0;
    endtask

    function automatic logic [15:0] rand_word();
        logic [3:0] op;
        op = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, NUM_OPS - 1));
        return {op, 12'($urandom)};
    endfunction

    task automatic start_prog();
        for (int i = 0; i < m_count; i++) exp_ins.push_back(m_buf[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input bit junk, output int n);
        n = 0;
        while (busy && n < 3000) begin
            if (junk) begin
                ld_en   = 1'($urandom_range(0, 1));
                ld_data = 16'($urandom);
                clr     = 1'($urandom_range(0, 1));
                start   = 1'($urandom_range(0, 1));
            end
            tick();
            n++;
        end
        ld_en = 1'b0;
        clr   = 1'b0;
        start = 1'b0;
        check("returned_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(m_count));
        check({tag, "_err"}, 32'(err), 32'(m_err));
        check({tag, "_ins_valid"}, 32'(ins_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ins"}, 32'(ins), 32'd0);
        check({tag, "_ins_valid"}, 32'(ins_valid), 32'd0);
        check({tag, "_last_res"}, last_res, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int d0;
        int h0;
        rst = 1'b0; ld_en = 1'b0; clr = 1'b0; start = 1'b0; ld_data = '0;
        #2;
        check_reset_outputs("reset");
        tick(); tick();
        rst = 1'b1;
        tick();

        // Two-instruction program with an always-ready data path.
        rdy_mode = 1; resp_delay = 1;
        load(16'h1230);
        load(16'h2341);
        d0 = done_cnt;
        start_prog();
        wait_idle(1'b0, n);
        check("basic_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_state("basic");

        // Stalled handshake: data path refuses for five cycles.
        rdy_mode = 0; resp_delay = -1;
        d0 = done_cnt;
        start_prog();
        repeat (5) tick();
        check("stall_valid", 32'(ins_valid), 32'd1);
        check("stall_ins", 32'(ins), 32'h1230);
        rdy_mode = 1;
        wait_idle(1'b0, n);
        check("stall_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Overflow, clear, then an empty program.
        for (int i = 0; i <= DEPTH; i++) load(16'h1000 | 16'(i));
        check_state("overflow");
        do_clr();
        check_state("clear");
        d0 = done_cnt; h0 = hs_total;
        start = 1'b1; tick(); start = 1'b0;
        check("empty_done", 32'(done), 32'd1);
        check("empty_no_valid", 32'(ins_valid), 32'd0);
        tick();
        check("empty_done_once", 32'(done), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);
        check("empty_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("empty_no_handshake", 32'(hs_total - h0), 32'd0);

        // Result never arrives.
        resp_en = 1'b0; rdy_mode = 1;
        load(16'h3456);
        d0 = done_cnt;
        start_prog();
        wait_idle(1'b0, n);
        m_err = 1'b1;
        check("timeout_cycles", 32'(n), 32'(TIMEOUT + 1));
        check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        check_state("timeout");
        resp_en = 1'b1;

        // Asynchronous reset while waiting on instruction 2 of 3.
        do_clr();
        for (int i = 0; i < 3; i++) load(16'(16'h4000 + 16'(i) * 16'h0111));
        resp_delay = 3;
        d0 = done_cnt; h0 = hs_total;
        start_prog();
        n = 0;
        while (hs_total < h0 + 2 && n < 100) begin tick(); n++; end
        check("midwait_reached", 32'(hs_total - h0), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midwait_reset");
        exp_ins.delete();
        tick(); tick();
        rst = 1'b1;
        m_count = 0; m_err = 1'b0;
        tick();
        check("midwait_no_done", 32'(done_cnt - d0), 32'd0);
        for (int i = 0; i < 3; i++) load(16'(16'h4000 + 16'(i) * 16'h0111));
        resp_delay = -1;
        d0 = done_cnt;
        start_prog();
        wait_idle(1'b0, n);
        check("rerun_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_state("rerun");

        // Opcode beyond the legal range.
        do_clr();
        load(16'hF000);
        check_state("opcode_f");

        // Randomised programs with junk control inputs while busy.
        rdy_mode = 2; resp_delay = -1;
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 4) == 0) do_clr();
            repeat ($urandom_range(0, DEPTH + 1)) load(rand_word());
            check_state("rand_load");
            d0 = done_cnt;
            start_prog();
            wait_idle(1'b1, n);
            check("rand_done_pulses", 32'(done_cnt - d0), 32'd1);
            check_state("rand_end");
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
